// File: rtl/decode_if.sv
// Bundle of every non-clock/reset signal of the decode stage:
// upstream handshake, register-file read ports, flush request,
// downstream handshake and the decoded instruction fields.
interface decode_if;
   logic        input_valid_i;
   logic        input_ready_o;
   logic [31:0] instr_i;
   logic [31:0] pc_i;
   logic [4:0]  reg_raddr1_o;
   logic [4:0]  reg_raddr2_o;
   logic [31:0] reg_rdata1_i;
   logic [31:0] reg_rdata2_i;
   logic        branch_i;
   logic        output_valid_o;
   logic        output_ready_i;
   logic [31:0] pc_o;
   logic [31:0] alu_operand1_o;
   logic [31:0] alu_operand2_o;
   logic [2:0]  alu_op_o;
   logic        alu_alt_o;
   logic        result_write_o;
   logic [4:0]  result_addr_o;
   logic [2:0]  branch_cond_o;
   logic        is_branch_o;
   logic [31:0] branch_base_o;
   logic [31:0] branch_offset_o;
   logic        ls_enable_o;
   logic        ls_write_o;
   logic [2:0]  ls_sel_o;
   logic [31:0] ls_write_data_o;
   logic        illegal_o;

   // Decode-stage view
   modport slave (
      input  input_valid_i, instr_i, pc_i, reg_rdata1_i, reg_rdata2_i,
             branch_i, output_ready_i,
      output input_ready_o, reg_raddr1_o, reg_raddr2_o, output_valid_o, pc_o,
             alu_operand1_o, alu_operand2_o, alu_op_o, alu_alt_o,
             result_write_o, result_addr_o, branch_cond_o, is_branch_o,
             branch_base_o, branch_offset_o, ls_enable_o, ls_write_o,
             ls_sel_o, ls_write_data_o, illegal_o
   );

   // Surrounding pipeline / testbench view
   modport master (
      output input_valid_i, instr_i, pc_i, reg_rdata1_i, reg_rdata2_i,
             branch_i, output_ready_i,
      input  input_ready_o, reg_raddr1_o, reg_raddr2_o, output_valid_o, pc_o,
             alu_operand1_o, alu_operand2_o, alu_op_o, alu_alt_o,
             result_write_o, result_addr_o, branch_cond_o, is_branch_o,
             branch_base_o, branch_offset_o, ls_enable_o, ls_write_o,
             ls_sel_o, ls_write_data_o, illegal_o
   );
endinterface

// File: rtl/decode.sv
// RV32I decode stage: reads the register file combinationally, decodes the
// instruction into ALU / branch / load-store controls and holds the result in
// a single output register with a valid/ready handshake and branch flush.
module decode (
   input  logic     clk_i,
   input  logic     rst_i,
   decode_if.slave  bus
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [2:0]  alu_op;
      logic        alu_alt;
      logic        result_write;
      logic [4:0]  result_addr;
      logic [2:0]  branch_cond;
      logic        is_branch;
      logic [31:0] branch_base;
      logic [31:0] branch_offset;
      logic        ls_enable;
      logic        ls_write;
      logic [2:0]  ls_sel;
      logic [31:0] ls_write_data;
      logic        illegal;
   } out_t;

   out_t out_q;
   out_t out_d;
   out_t dec;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic        writes_rd;
   logic        capture;

   assign opcode = bus.instr_i[6:0];
   assign funct3 = bus.instr_i[14:12];
   assign rd     = bus.instr_i[11:7];

   assign bus.reg_raddr1_o = bus.instr_i[19:15];
   assign bus.reg_raddr2_o = bus.instr_i[24:20];

   // x0 always reads as zero whatever the register file returns
   assign rs1_val = (bus.instr_i[19:15] == 5'd0) ? 32'd0 : bus.reg_rdata1_i;
   assign rs2_val = (bus.instr_i[24:20] == 5'd0) ? 32'd0 : bus.reg_rdata2_i;

   assign imm_i = {{20{bus.instr_i[31]}}, bus.instr_i[31:20]};
   assign imm_s = {{20{bus.instr_i[31]}}, bus.instr_i[31:25], bus.instr_i[11:7]};
   assign imm_b = {{19{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[7],
                   bus.instr_i[30:25], bus.instr_i[11:8], 1'b0};
   assign imm_u = {bus.instr_i[31:12], 12'b0};
   assign imm_j = {{11{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[19:12],
                   bus.instr_i[20], bus.instr_i[30:21], 1'b0};

   assign bus.input_ready_o = !out_q.valid || bus.output_ready_i;
   assign capture = bus.input_valid_i && bus.input_ready_o && !bus.branch_i;

   // Decode the offered instruction; fields an opcode does not use stay 0
   always_comb begin
      dec             = '0;
      writes_rd       = 1'b0;
      dec.valid       = 1'b1;
      dec.pc          = bus.pc_i;
      dec.result_addr = rd;
      case (opcode)
         OPC_LUI: begin
            dec.op2   = imm_u;
            writes_rd = 1'b1;
         end
         OPC_AUIPC: begin
            dec.op1   = bus.pc_i;
            dec.op2   = imm_u;
            writes_rd = 1'b1;
         end
         OPC_JAL: begin
            dec.op1           = bus.pc_i;
            dec.op2           = 32'd4;
            dec.branch_base   = bus.pc_i;
            dec.branch_offset = imm_j;
            dec.is_branch     = 1'b1;
            writes_rd         = 1'b1;
         end
         OPC_JALR: begin
            dec.op1           = bus.pc_i;
            dec.op2           = 32'd4;
            dec.branch_base   = rs1_val;
            dec.branch_offset = imm_i;
            dec.is_branch     = 1'b1;
            writes_rd         = 1'b1;
         end
         OPC_BRANCH: begin
            dec.op1           = rs1_val;
            dec.op2           = rs2_val;
            dec.branch_base   = bus.pc_i;
            dec.branch_offset = imm_b;
            dec.branch_cond   = funct3;
            dec.is_branch     = 1'b1;
         end
         OPC_LOAD: begin
            dec.op1       = rs1_val;
            dec.op2       = imm_i;
            dec.ls_enable = 1'b1;
            dec.ls_sel    = funct3;
            writes_rd     = 1'b1;
         end
         OPC_STORE: begin
            dec.op1           = rs1_val;
            dec.op2           = imm_s;
            dec.ls_enable     = 1'b1;
            dec.ls_write      = 1'b1;
            dec.ls_write_data = rs2_val;
            dec.ls_sel        = funct3;
         end
         OPC_OPIMM: begin
            dec.op1     = rs1_val;
            dec.op2     = imm_i;
            dec.alu_op  = funct3;
            dec.alu_alt = (funct3 == 3'b101) ? bus.instr_i[30] : 1'b0;
            writes_rd   = 1'b1;
         end
         OPC_OP: begin
            dec.op1     = rs1_val;
            dec.op2     = rs2_val;
            dec.alu_op  = funct3;
            dec.alu_alt = bus.instr_i[30];
            writes_rd   = 1'b1;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
      dec.result_write = writes_rd && (rd != 5'd0);
   end

   // Output register next state: flush beats capture beats drain; a stall holds
   always_comb begin
      out_d = out_q;
      if (bus.branch_i) begin
         out_d.valid = 1'b0;
      end else if (capture) begin
         out_d = dec;
      end else if (bus.output_ready_i) begin
         out_d.valid = 1'b0;
      end
   end

   // Output register with asynchronous clear
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign bus.output_valid_o  = out_q.valid;
   assign bus.pc_o            = out_q.pc;
   assign bus.alu_operand1_o  = out_q.op1;
   assign bus.alu_operand2_o  = out_q.op2;
   assign bus.alu_op_o        = out_q.alu_op;
   assign bus.alu_alt_o       = out_q.alu_alt;
   assign bus.result_write_o  = out_q.result_write;
   assign bus.result_addr_o   = out_q.result_addr;
   assign bus.branch_cond_o   = out_q.branch_cond;
   assign bus.is_branch_o     = out_q.is_branch;
   assign bus.branch_base_o   = out_q.branch_base;
   assign bus.branch_offset_o = out_q.branch_offset;
   assign bus.ls_enable_o     = out_q.ls_enable;
   assign bus.ls_write_o      = out_q.ls_write;
   assign bus.ls_sel_o        = out_q.ls_sel;
   assign bus.ls_write_data_o = out_q.ls_write_data;
   assign bus.illegal_o       = out_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Testbench for the decode stage: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model of the instruction set and the handshake rules.
module tb_decode;

   logic clk;
   logic rst;
   decode_if dif ();

   decode dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [2:0]  alu_op;
      logic        alu_alt;
      logic        rw;
      logic [4:0]  rd;
      logic [2:0]  cond;
      logic        isb;
      logic [31:0] base;
      logic [31:0] off;
      logic        lse;
      logic        lsw;
      logic [2:0]  sel;
      logic [31:0] wdata;
      logic        ill;
   } exp_t;

   int   vectors = 0;
   int   miscompares = 0;
   logic exp_valid;
   exp_t exp_q;

   // Reference decode: what the ISA says each instruction class produces
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] d1, input logic [31:0] d2);
      exp_t        e;
      logic [31:0] sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ii;
      logic [31:0] is;
      logic [31:0] ib;
      logic [31:0] iu;
      logic [31:0] ij;
      logic [2:0]  f3;
      bit          wr;
      e   = '0;
      wr  = 0;
      f3  = ins[14:12];
      sgn = ins[31] ? 32'hFFFF_FFFF : 32'h0;
      a   = (ins[19:15] == 5'd0) ? 32'd0 : d1;
      b   = (ins[24:20] == 5'd0) ? 32'd0 : d2;
      ii  = (sgn << 11) | 32'(ins[30:20]);
      is  = (sgn << 11) | (32'(ins[30:25]) << 5) | 32'(ins[11:7]);
      ib  = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      iu  = ins & 32'hFFFF_F000;
      ij  = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      e.pc = pc;
      e.rd = ins[11:7];
      case (ins[6:0])
         7'h37: begin e.op2 = iu; wr = 1; end
         7'h17: begin e.op1 = pc; e.op2 = iu; wr = 1; end
         7'h6F: begin e.op1 = pc; e.op2 = 4; e.base = pc; e.off = ij; e.isb = 1; wr = 1; end
         7'h67: begin e.op1 = pc; e.op2 = 4; e.base = a; e.off = ii; e.isb = 1; wr = 1; end
         7'h63: begin e.op1 = a; e.op2 = b; e.base = pc; e.off = ib; e.cond = f3; e.isb = 1; end
         7'h03: begin e.op1 = a; e.op2 = ii; e.lse = 1; e.sel = f3; wr = 1; end
         7'h23: begin e.op1 = a; e.op2 = is; e.lse = 1; e.lsw = 1; e.wdata = b; e.sel = f3; end
         7'h13: begin e.op1 = a; e.op2 = ii; e.alu_op = f3; e.alu_alt = (f3 == 3'd5) && ins[30]; wr = 1; end
         7'h33: begin e.op1 = a; e.op2 = b; e.alu_op = f3; e.alu_alt = ins[30]; wr = 1; end
         default: e.ill = 1;
      endcase
      e.rw = wr && (ins[11:7] != 5'd0);
      return e;
   endfunction

   // Model of the stage register: flush, then capture, then drain, else hold
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_valid = 1'b0;
         exp_q     = '0;
      end else if (dif.branch_i) begin
         exp_valid = 1'b0;
      end else if (dif.input_valid_i && (!exp_valid || dif.output_ready_i)) begin
         exp_q     = model(dif.instr_i, dif.pc_i, dif.reg_rdata1_i, dif.reg_rdata2_i);
         exp_valid = 1'b1;
      end else if (dif.output_ready_i) begin
         exp_valid = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_output(input exp_t e);
      check("pc",       dif.pc_o, e.pc);
      check("op1",      dif.alu_operand1_o, e.op1);
      check("op2",      dif.alu_operand2_o, e.op2);
      check("alu_op",   32'(dif.alu_op_o), 32'(e.alu_op));
      check("alu_alt",  32'(dif.alu_alt_o), 32'(e.alu_alt));
      check("rwrite",   32'(dif.result_write_o), 32'(e.rw));
      check("raddr",    32'(dif.result_addr_o), 32'(e.rd));
      check("cond",     32'(dif.branch_cond_o), 32'(e.cond));
      check("isbranch", 32'(dif.is_branch_o), 32'(e.isb));
      check("base",     dif.branch_base_o, e.base);
      check("offset",   dif.branch_offset_o, e.off);
      check("ls_en",    32'(dif.ls_enable_o), 32'(e.lse));
      check("ls_wr",    32'(dif.ls_write_o), 32'(e.lsw));
      check("ls_sel",   32'(dif.ls_sel_o), 32'(e.sel));
      check("ls_wdata", dif.ls_write_data_o, e.wdata);
      check("illegal",  32'(dif.illegal_o), 32'(e.ill));
   endtask

   // Every cycle, away from the clock edge, compare the DUT with the model
   always @(negedge clk) begin
      check("out_valid", 32'(dif.output_valid_o), 32'(exp_valid));
      check("in_ready",  32'(dif.input_ready_o), 32'(!exp_valid || dif.output_ready_i));
      check("raddr1",    32'(dif.reg_raddr1_o), 32'(dif.instr_i[19:15]));
      check("raddr2",    32'(dif.reg_raddr2_o), 32'(dif.instr_i[24:20]));
      if (rst || exp_valid) check_output(exp_q);
   end

   task automatic apply_stimulus(input logic v, input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic rdy, input logic br);
      @(posedge clk);
      #1;
      dif.input_valid_i  = v;
      dif.instr_i        = ins;
      dif.pc_i           = p;
      dif.reg_rdata1_i   = d1;
      dif.reg_rdata2_i   = d2;
      dif.output_ready_i = rdy;
      dif.branch_i       = br;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  opc [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                7'h23, 7'h13, 7'h33, 7'h7F, 7'h0B, 7'h00};
      logic [31:0] r;
      r = $urandom();
      r[6:0] = opc[$urandom_range(0, 11)];
      if ($urandom_range(0, 3) == 0) r[19:15] = 5'd0;
      if ($urandom_range(0, 3) == 0) r[24:20] = 5'd0;
      if ($urandom_range(0, 3) == 0) r[11:7]  = 5'd0;
      return r;
   endfunction

   localparam logic [31:0] ADDI = 32'h0051_0093;
   localparam logic [31:0] LUI  = 32'h1234_50B7;
   localparam logic [31:0] SW   = 32'h0032_2423;

   initial begin
      rst = 1'b1;
      dif.input_valid_i  = 1'b0;
      dif.instr_i        = 32'h0;
      dif.pc_i           = 32'h0;
      dif.reg_rdata1_i   = 32'h0;
      dif.reg_rdata2_i   = 32'h0;
      dif.output_ready_i = 1'b1;
      dif.branch_i       = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_valid", 32'(dif.output_valid_o), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // ADDI x1,x2,5
      apply_stimulus(1, ADDI, 32'h1000, 32'h10, 32'h55, 1, 0);
      @(negedge clk);
      check("addi_raddr1", 32'(dif.reg_raddr1_o), 32'd2);
      apply_stimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
      @(negedge clk);
      check("addi_op1", dif.alu_operand1_o, 32'h10);
      check("addi_op2", dif.alu_operand2_o, 32'h5);
      check("addi_aluop", 32'(dif.alu_op_o), 32'h0);
      check("addi_rw", 32'(dif.result_write_o), 32'h1);
      check("addi_rd", 32'(dif.result_addr_o), 32'h1);

      // LUI x1,0x12345
      apply_stimulus(1, LUI, 32'h2000, 32'h77, 32'h88, 1, 0);
      apply_stimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
      @(negedge clk);
      check("lui_op1", dif.alu_operand1_o, 32'h0);
      check("lui_op2", dif.alu_operand2_o, 32'h1234_5000);
      check("lui_rw", 32'(dif.result_write_o), 32'h1);

      // SW x3,8(x4)
      apply_stimulus(1, SW, 32'h3000, 32'h100, 32'hAB, 1, 0);
      apply_stimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
      @(negedge clk);
      check("sw_op1", dif.alu_operand1_o, 32'h100);
      check("sw_op2", dif.alu_operand2_o, 32'h8);
      check("sw_lse", 32'(dif.ls_enable_o), 32'h1);
      check("sw_lsw", 32'(dif.ls_write_o), 32'h1);
      check("sw_wdata", dif.ls_write_data_o, 32'hAB);
      check("sw_sel", 32'(dif.ls_sel_o), 32'h2);
      check("sw_rw", 32'(dif.result_write_o), 32'h0);

      // Back-pressure: ADDI held for three stalled cycles while LUI waits
      apply_stimulus(1, ADDI, 32'h4000, 32'h10, 32'h0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1, LUI, 32'h4004, 32'h0, 32'h0, 0, 0);
         @(negedge clk);
         check("bp_in_ready", 32'(dif.input_ready_o), 32'h0);
         check("bp_hold_op2", dif.alu_operand2_o, 32'h5);
         check("bp_hold_pc", dif.pc_o, 32'h4000);
      end
      apply_stimulus(1, LUI, 32'h4004, 32'h0, 32'h0, 1, 0);
      apply_stimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
      @(negedge clk);
      check("bp_next_valid", 32'(dif.output_valid_o), 32'h1);
      check("bp_next_op2", dif.alu_operand2_o, 32'h1234_5000);
      check("bp_next_pc", dif.pc_o, 32'h4004);

      // Flush while valid with a new instruction offered
      apply_stimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
      apply_stimulus(1, ADDI, 32'h5000, 32'h10, 32'h0, 0, 0);
      apply_stimulus(1, LUI, 32'h5004, 32'h0, 32'h0, 0, 1);
      @(negedge clk);
      check("flush_pre_valid", 32'(dif.output_valid_o), 32'h1);
      apply_stimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      check("flush_valid", 32'(dif.output_valid_o), 32'h0);

      // Illegal opcode
      apply_stimulus(1, 32'hFFFF_FFFF, 32'h6000, 32'h1, 32'h2, 1, 0);
      apply_stimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      check("ill_valid", 32'(dif.output_valid_o), 32'h1);
      check("ill_flag", 32'(dif.illegal_o), 32'h1);
      check("ill_rw", 32'(dif.result_write_o), 32'h0);

      // Reset pulsed mid-stall clears immediately; next edge may capture
      apply_stimulus(1, LUI, 32'h7000, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      check("rst_pre_valid", 32'(dif.output_valid_o), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_valid", 32'(dif.output_valid_o), 32'h0);
      check("rst_async_op2", dif.alu_operand2_o, 32'h0);
      check("rst_async_ill", 32'(dif.illegal_o), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      apply_stimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      check("rst_first_capture", dif.alu_operand2_o, 32'h1234_5000);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         apply_stimulus($urandom_range(0, 3) != 0, rand_instr(), $urandom() & 32'hFFFF_FFFC,
                        $urandom(), $urandom(), $urandom_range(0, 3) != 0,
                        $urandom_range(0, 9) == 0);
         if (i == 400) begin
            #2 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
         end
      end
      apply_stimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-002 SHALL have port rst_i, input, 1: reset; one clock; reset is asynchronous and active-high.
REQ-003 SHALL have ports input_valid_i (in, 1), input_ready_o (out, 1), instr_i (in, 32), pc_i (in, 32): upstream handshake, instruction word and its address.
REQ-004 SHALL have ports reg_raddr1_o, reg_raddr2_o (out, 5), reg_rdata1_i, reg_rdata2_i (in, 32): register-file read ports with combinational (same-cycle) read data.
REQ-005 SHALL have port branch_i, input, 1: downstream flush request, from a taken branch.
REQ-006 SHALL have ports output_valid_o (out, 1), output_ready_i (in, 1): downstream handshake.
REQ-007 SHALL have port pc_o, out, 32: PC of the registered instruction.
REQ-008 SHALL have ports alu_operand1_o, alu_operand2_o (out, 32), alu_op_o (out, 3), alu_alt_o (out, 1): ALU operands, funct3 operation and alternate select.
REQ-009 SHALL have ports result_write_o (out, 1), result_addr_o (out, 5): register writeback enable and destination.
REQ-010 SHALL have ports branch_cond_o (out, 3), is_branch_o (out, 1), branch_base_o, branch_offset_o (out, 32): branch/jump information.
REQ-011 SHALL have ports ls_enable_o, ls_write_o (out, 1), ls_sel_o (out, 3), ls_write_data_o (out, 32): load/store control.
REQ-012 SHALL have port illegal_o, out, 1: unsupported opcode flag.

Function
REQ-013 SHALL drive reg_raddr1_o=instr_i[19:15] and reg_raddr2_o=instr_i[24:20] combinationally.
REQ-014 SHALL force the read operand to 0 when the corresponding address is 0, regardless of the reg_rdata value.
REQ-015 SHALL drive input_ready_o = !output_valid_o || output_ready_i, combinationally.
REQ-016 SHALL capture on input_valid_i && input_ready_o && !branch_i. Latency is 1 cycle: outputs are valid on the next rising edge.
REQ-017 SHALL keep every output stable while output_valid_o && !output_ready_i.
REQ-018 SHALL clear output_valid_o on the edge after branch_i=1, discarding any input presented in the same cycle. branch_i has priority over capture and over stall.
REQ-019 SHALL clear output_valid_o when the output transfer completes and no new capture occurs.
REQ-020 SHALL sign-extend immediates to 32 bits:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'b0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
REQ-021 SHALL decode by opcode (instr[6:0]) as follows:
  - LUI: op1=0, op2=U.
  - AUIPC: op1=pc, op2=U.
  - JAL: op1=pc, op2=4; base=pc, offset=J.
  - JALR: op1=pc, op2=4; base=rs1, offset=I.
  - BRANCH: op1=rs1, op2=rs2; base=pc, offset=B; branch_cond=funct3.
  - LOAD: op1=rs1, op2=I; ls_enable=1, ls_sel=funct3.
  - STORE: op1=rs1, op2=S; ls_enable=1, ls_write=1, ls_write_data=rs2, ls_sel=funct3.
  - OP-IMM: op1=rs1, op2=I.
  - OP: op1=rs1, op2=rs2.
REQ-022 SHALL set alu_op_o=funct3 for OP and OP-IMM, and 000 otherwise. alu_alt_o=instr[30] for OP, and for OP-IMM with funct3=101 only; 0 otherwise.
REQ-023 SHALL set is_branch_o=1 for JAL, JALR and BRANCH only.
REQ-024 SHALL set result_write_o=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, but 0 whenever rd=0. result_addr_o=instr[11:7].
REQ-025 SHALL handle an unknown opcode by setting illegal_o=1, with result_write_o, ls_enable_o and is_branch_o all 0. The instruction is still handed downstream.
REQ-026 SHALL drive all unused outputs for a given opcode to 0.

Reset
REQ-027 SHALL clear output_valid_o and all registered outputs to 0 immediately while rst_i=1, independent of clk_i.
REQ-028 SHALL discard any in-flight instruction when reset is asserted mid-operation. The first capture is allowed on the first edge after rst_i falls.

Verification
REQ-029 SHALL cover ADDI x1,x2,5: instr 0x00510093, reg_rdata1_i=0x10 -> reg_raddr1_o=2; next cycle op1=0x10, op2=5, alu_op=000, result_write=1, result_addr=1.
REQ-030 SHALL cover LUI x1,0x12345: instr 0x123450B7 -> op1=0, op2=0x12345000, result_write=1.
REQ-031 SHALL cover SW x3,8(x4): instr 0x00322423, rdata1=0x100, rdata2=0xAB -> op1=0x100, op2=8, ls_enable=1, ls_write=1, ls_write_data=0xAB, ls_sel=010, result_write=0.
REQ-032 SHALL cover back-pressure: output_ready_i=0 for 3 cycles with a new instruction offered -> input_ready_o=0 and outputs unchanged; after ready rises, the next instruction appears 1 cycle later.
REQ-033 SHALL cover flush: branch_i=1 while output_valid_o=1 and input_valid_i=1 -> output_valid_o=0 next cycle, and the offered input is not captured.
REQ-034 SHALL cover illegal and reset: instr 0xFFFFFFFF -> illegal_o=1, result_write=0; rst_i pulsed mid-stall -> output_valid_o=0 immediately, without waiting for a clock edge.
